// File: rtl/sc_speedsched_pkg.sv
// Shared encodings and default terminal counts for the Frogger lane tick scheduler.
package sc_speedsched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } sched_state_e;

  typedef enum logic [1:0] {
    LVL1 = 2'd0,
    LVL2 = 2'd1,
    LVL3 = 2'd2,
    LVL4 = 2'd3
  } level_e;

  localparam int unsigned DEF_DATAWIDTH = 32'd25;
  localparam int unsigned DEF_TC_LVL1   = 32'd33554431;
  localparam int unsigned DEF_TC_LVL2   = 32'd16777215;
  localparam int unsigned DEF_TC_LVL3   = 32'd8388607;
  localparam int unsigned DEF_TC_LVL4   = 32'd4194303;
  localparam int unsigned DEF_NUM_LANES = 32'd4;

  // Next level, saturating at the fastest setting.
  function automatic level_e level_next_sat(input level_e lvl);
    level_e nxt;
    case (lvl)
      LVL1:    nxt = LVL2;
      LVL2:    nxt = LVL3;
      LVL3:    nxt = LVL4;
      default: nxt = LVL4;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/sc_speed_prescaler.sv
// Shared prescaler: counts 0..tc_i while enabled, flags the terminal-count cycle.
module sc_speed_prescaler #(
  parameter int unsigned DATAWIDTH = 32'd25
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clr_i,
  input  logic                 en_i,
  input  logic [DATAWIDTH-1:0] tc_i,
  output logic                 wrap_o
);

  logic [DATAWIDTH-1:0] count_q;
  logic [DATAWIDTH-1:0] count_d;
  logic                 at_tc_s;

  assign at_tc_s = (count_q == tc_i);
  assign wrap_o  = en_i && at_tc_s;

  // Clear has priority; the counter returns to zero at tc so it never wraps naturally.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      if (at_tc_s) begin
        count_d = '0;
      end else begin
        count_d = count_q + {{(DATAWIDTH-1){1'b0}}, 1'b1};
      end
    end else begin
      count_d = count_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/sc_speed_scheduler.sv
// Lane tick scheduler: run/pause/stop FSM, level-up sequencing and lane dispatch.
// Define SPEEDSCHED_LANE_RR_EN for round-robin lane ticks; otherwise ticks broadcast.
module sc_speed_scheduler
  import sc_speedsched_pkg::*;
#(
  parameter int unsigned SPEEDSCHED_DATAWIDTH = DEF_DATAWIDTH,
  parameter int unsigned SPEEDSCHED_TC_LVL1   = DEF_TC_LVL1,
  parameter int unsigned SPEEDSCHED_TC_LVL2   = DEF_TC_LVL2,
  parameter int unsigned SPEEDSCHED_TC_LVL3   = DEF_TC_LVL3,
  parameter int unsigned SPEEDSCHED_TC_LVL4   = DEF_TC_LVL4,
  parameter int unsigned SPEEDSCHED_NUM_LANES = DEF_NUM_LANES
) (
  input  logic                            SC_SPEEDSCHED_CLOCK_50,
  input  logic                            SC_SPEEDSCHED_RESET_InHigh,
  input  logic                            SC_SPEEDSCHED_start_InLow,
  input  logic                            SC_SPEEDSCHED_pause_InLow,
  input  logic                            SC_SPEEDSCHED_stop_InLow,
  input  logic                            SC_SPEEDSCHED_levelup_InLow,
  output logic [SPEEDSCHED_NUM_LANES-1:0] SC_SPEEDSCHED_tick_OutBUS,
  output logic [1:0]                      SC_SPEEDSCHED_level_OutBUS,
  output logic                            SC_SPEEDSCHED_running_OutHigh
);

  localparam logic [SPEEDSCHED_DATAWIDTH-1:0] TC1 = SPEEDSCHED_DATAWIDTH'(SPEEDSCHED_TC_LVL1);
  localparam logic [SPEEDSCHED_DATAWIDTH-1:0] TC2 = SPEEDSCHED_DATAWIDTH'(SPEEDSCHED_TC_LVL2);
  localparam logic [SPEEDSCHED_DATAWIDTH-1:0] TC3 = SPEEDSCHED_DATAWIDTH'(SPEEDSCHED_TC_LVL3);
  localparam logic [SPEEDSCHED_DATAWIDTH-1:0] TC4 = SPEEDSCHED_DATAWIDTH'(SPEEDSCHED_TC_LVL4);

  logic clk;
  logic rst;
  logic start_s;
  logic pause_s;
  logic stop_s;
  logic levelup_s;

  assign clk       = SC_SPEEDSCHED_CLOCK_50;
  assign rst       = SC_SPEEDSCHED_RESET_InHigh;
  assign start_s   = ~SC_SPEEDSCHED_start_InLow;
  assign pause_s   = ~SC_SPEEDSCHED_pause_InLow;
  assign stop_s    = ~SC_SPEEDSCHED_stop_InLow;
  assign levelup_s = ~SC_SPEEDSCHED_levelup_InLow;

  sched_state_e                      state_q, state_d;
  level_e                            level_q, level_d;
  logic                              pending_q, pending_d;
  logic                              running_q, running_d;
  logic [SPEEDSCHED_NUM_LANES-1:0]   tick_q, tick_d;
  logic [SPEEDSCHED_DATAWIDTH-1:0]   tc_s;
  logic                              wrap_s;
  logic                              tick_evt_s;
  logic                              pres_clr_s;
  logic                              pres_en_s;

  // Terminal count for the current level.
  always_comb begin
    tc_s = TC1;
    case (level_q)
      LVL1:    tc_s = TC1;
      LVL2:    tc_s = TC2;
      LVL3:    tc_s = TC3;
      LVL4:    tc_s = TC4;
      default: tc_s = TC1;
    endcase
  end

  assign pres_clr_s = stop_s || (state_q == ST_IDLE);
  assign pres_en_s  = (state_q == ST_RUN);

  sc_speed_prescaler #(
    .DATAWIDTH (SPEEDSCHED_DATAWIDTH)
  ) u_prescaler (
    .clk_i  (clk),
    .rst_i  (rst),
    .clr_i  (pres_clr_s),
    .en_i   (pres_en_s),
    .tc_i   (tc_s),
    .wrap_o (wrap_s)
  );

  // A stop in the wrap cycle swallows the tick and any level change.
  assign tick_evt_s = wrap_s && !stop_s;

  // Next-state logic; stop overrides start and pause.
  always_comb begin
    state_d = state_q;
    if (stop_s) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_s) state_d = ST_RUN;
          else         state_d = ST_IDLE;
        end
        ST_RUN: begin
          if (pause_s) state_d = ST_PAUSE;
          else         state_d = ST_RUN;
        end
        ST_PAUSE: begin
          if (pause_s) state_d = ST_PAUSE;
          else         state_d = ST_RUN;
        end
        default: state_d = ST_IDLE;
      endcase
    end
    running_d = (state_d == ST_RUN);
  end

  // Level-up requests collapse into one pending flag, consumed at the next wrap.
  always_comb begin
    level_d   = level_q;
    pending_d = pending_q || levelup_s;
    if (level_q == LVL4) begin
      pending_d = 1'b0;
    end else if (tick_evt_s) begin
      if (pending_q || levelup_s) begin
        level_d = level_next_sat(level_q);
      end else begin
        level_d = level_q;
      end
      pending_d = 1'b0;
    end else begin
      level_d = level_q;
    end
  end

`ifdef SPEEDSCHED_LANE_RR_EN
  localparam int unsigned LANE_W = $clog2(SPEEDSCHED_NUM_LANES);
  localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(SPEEDSCHED_NUM_LANES - 32'd1);

  logic [LANE_W-1:0] lane_q, lane_d;

  // One lane per tick, pointer advances after each tick.
  always_comb begin
    lane_d = lane_q;
    tick_d = '0;
    if (stop_s) begin
      lane_d = '0;
    end else if (tick_evt_s) begin
      tick_d[lane_q] = 1'b1;
      if (lane_q == LANE_LAST) lane_d = '0;
      else                     lane_d = lane_q + {{(LANE_W-1){1'b0}}, 1'b1};
    end else begin
      lane_d = lane_q;
    end
  end

  // Lane pointer register.
  always_ff @(posedge clk) begin
    if (rst) begin
      lane_q <= '0;
    end else begin
      lane_q <= lane_d;
    end
  end
`else
  // Broadcast: every lane ticks together.
  always_comb begin
    tick_d = '0;
    if (tick_evt_s) tick_d = '1;
    else            tick_d = '0;
  end
`endif

  // State, level and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      level_q   <= LVL1;
      pending_q <= 1'b0;
      running_q <= 1'b0;
      tick_q    <= '0;
    end else begin
      state_q   <= state_d;
      level_q   <= level_d;
      pending_q <= pending_d;
      running_q <= running_d;
      tick_q    <= tick_d;
    end
  end

  assign SC_SPEEDSCHED_tick_OutBUS     = tick_q;
  assign SC_SPEEDSCHED_level_OutBUS    = level_q;
  assign SC_SPEEDSCHED_running_OutHigh = running_q;

endmodule

// File: tb/tb_sc_speed_scheduler.sv
// Directed bench for sc_speed_scheduler with small terminal counts (7,5,3,1), 4 lanes.
module tb_sc_speed_scheduler;

  localparam int NL = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_n;
  logic          pause_n;
  logic          stop_n;
  logic          lvl_n;
  logic [NL-1:0] tick;
  logic [1:0]    level;
  logic          running;

  int checks   = 0;
  int failures = 0;
  int exp_lane = 0;

  always #5 clk = ~clk;

  sc_speed_scheduler #(
    .SPEEDSCHED_DATAWIDTH (4),
    .SPEEDSCHED_TC_LVL1   (7),
    .SPEEDSCHED_TC_LVL2   (5),
    .SPEEDSCHED_TC_LVL3   (3),
    .SPEEDSCHED_TC_LVL4   (1),
    .SPEEDSCHED_NUM_LANES (NL)
  ) dut (
    .SC_SPEEDSCHED_CLOCK_50        (clk),
    .SC_SPEEDSCHED_RESET_InHigh    (rst),
    .SC_SPEEDSCHED_start_InLow     (start_n),
    .SC_SPEEDSCHED_pause_InLow     (pause_n),
    .SC_SPEEDSCHED_stop_InLow      (stop_n),
    .SC_SPEEDSCHED_levelup_InLow   (lvl_n),
    .SC_SPEEDSCHED_tick_OutBUS     (tick),
    .SC_SPEEDSCHED_level_OutBUS    (level),
    .SC_SPEEDSCHED_running_OutHigh (running)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NL-1:0] exp_bus();
    logic [NL-1:0] one;
    one = 1;
`ifdef SPEEDSCHED_LANE_RR_EN
    return one << exp_lane;
`else
    return '1;
`endif
  endfunction

  // Waits for the next tick (bounded), checks spacing, lane bus and level.
  task automatic tick_period(input string tag, input int exp_n, input int exp_lvl);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (tick == '0 && n < exp_n + 4);
    chk({tag, "_spacing"}, n, exp_n);
    chk({tag, "_bus"}, tick, exp_bus());
    chk({tag, "_level"}, level, exp_lvl);
    exp_lane = (exp_lane + 1) % NL;
  endtask

  task automatic pulse_levelup();
    lvl_n = 1'b0;
    step();
    lvl_n = 1'b1;
  endtask

  task automatic do_start();
    start_n = 1'b0;
    step();
    start_n = 1'b1;
    chk("start_running", running, 1);
  endtask

  initial begin
    logic [NL-1:0] seen;
    rst = 1'b1; start_n = 1'b1; pause_n = 1'b1; stop_n = 1'b1; lvl_n = 1'b1;
    repeat (3) step();
    chk("rst_tick", tick, 0);
    chk("rst_level", level, 0);
    chk("rst_running", running, 0);
    rst = 1'b0;
    repeat (3) step();
    chk("idle_running", running, 0);
    chk("idle_tick", tick, 0);

    // Start and steady ticking at level 0.
    do_start();
    tick_period("t1_first", 8, 0);
    for (int i = 0; i < 4; i++) tick_period("t1_next", 8, 0);

    // Pause with held count 4; resume continues from it.
    repeat (3) step();
    pause_n = 1'b0;
    seen = '0;
    step();
    chk("t3_pause_running", running, 0);
    seen = seen | tick;
    for (int i = 0; i < 9; i++) begin
      step();
      seen = seen | tick;
    end
    chk("t3_no_ticks", seen, 0);
    pause_n = 1'b1;
    step();
    chk("t3_resume_running", running, 1);
    tick_period("t3_resume", 4, 0);

    // Pause in the wrap cycle still ticks, then pauses at count 0.
    repeat (7) step();
    pause_n = 1'b0;
    step();
    chk("t4_wrap_tick", tick, exp_bus());
    exp_lane = (exp_lane + 1) % NL;
    chk("t4_running", running, 0);
    seen = '0;
    for (int i = 0; i < 3; i++) begin
      step();
      seen = seen | tick;
    end
    chk("t4_no_ticks", seen, 0);
    pause_n = 1'b1;
    step();
    tick_period("t4_resume", 8, 0);

    // Level-up mid-period applies at the next wrap.
    repeat (3) step();
    pulse_levelup();
    chk("t2_level_held", level, 0);
    tick_period("t2_apply", 4, 1);
    tick_period("t2_lvl1", 6, 1);
    pulse_levelup();
    tick_period("t2_apply2", 5, 2);
    tick_period("t2_lvl2", 4, 2);

    // Stop at level 2: idle, level kept, lane pointer back to 0.
    repeat (2) step();
    stop_n = 1'b0;
    step();
    chk("t5_running", running, 0);
    chk("t5_tick", tick, 0);
    chk("t5_level", level, 2);
    seen = '0;
    for (int i = 0; i < 4; i++) begin
      step();
      seen = seen | tick;
    end
    chk("t5_no_ticks", seen, 0);
    stop_n = 1'b1;
    exp_lane = 0;
    step();
    chk("t5_idle_after_stop", running, 0);
    do_start();
    tick_period("t5_restart", 4, 2);

    // Saturation at level 3.
    pulse_levelup();
    tick_period("t2_apply3", 3, 3);
    tick_period("t2_lvl3", 2, 3);
    pulse_levelup();
    tick_period("t2_sat_a", 1, 3);
    pulse_levelup();
    tick_period("t2_sat_b", 1, 3);
    tick_period("t2_sat_c", 2, 3);

    // Reset back to level 0; multiple pulses in one period count as one.
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_lane = 0;
    chk("rst2_level", level, 0);
    do_start();
    repeat (2) step();
    pulse_levelup();
    step();
    pulse_levelup();
    tick_period("multi_pulse", 3, 1);
    tick_period("multi_next", 6, 1);

    // Reset mid-period discards the pending request.
    repeat (2) step();
    pulse_levelup();
    step();
    rst = 1'b1;
    step();
    chk("t6_tick", tick, 0);
    chk("t6_level", level, 0);
    chk("t6_running", running, 0);
    rst = 1'b0;
    exp_lane = 0;
    step();
    do_start();
    tick_period("t6_first", 8, 0);
    tick_period("t6_second", 8, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
